// File: rtl/srl_fifo.sv
// srl_fifo
//   Show-ahead (first-word-fall-through) FIFO built on an SRL32-style shift
//   register. Writes shift new words in at srl[0]. The oldest word is read
//   through an address tap at srl[count-1]. A pop never moves storage; it only
//   decrements the count.
//
// Parameters
//   DATA_W  width of each stored word (1..64)
//   DEPTH   number of entries, power of 2 (2..32)
//   ADDR_W  log2(DEPTH)
//
// Ports
//   clk_in       rising-edge clock for all state
//   rst_n_in     synchronous active-low reset
//   wr_en_in     push request (accepted when not full, or when popping)
//   wr_data_in   word to push
//   rd_en_in     pop request (accepted when not empty)
//   rd_data_out  oldest stored word, zero while empty
//   full_out     registered, count == DEPTH
//   empty_out    registered, count == 0
//   count_out    number of stored words, 0..DEPTH
//   ovf_out      sticky rejected-push flag   (only with SRL_FIFO_ERR_FLAG_EN)
//   udf_out      sticky pop-on-empty flag    (only with SRL_FIFO_ERR_FLAG_EN)
//
// Optional feature macro: SRL_FIFO_ERR_FLAG_EN

module srl_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              wr_en_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              rd_en_in,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              full_out,
  output logic              empty_out,
`ifdef SRL_FIFO_ERR_FLAG_EN
  output logic              ovf_out,
  output logic              udf_out,
`endif
  output logic [ADDR_W:0]   count_out
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] srl [DEPTH];
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W-1:0] tap_addr;
  logic              wr_ok;
  logic              rd_ok;
  logic              shift_en;

  // A push into a full FIFO is allowed only when a pop frees a slot on the
  // same edge.
  assign rd_ok    = rd_en_in & ~empty_out;
  assign wr_ok    = wr_en_in & (~full_out | rd_ok);
  assign shift_en = wr_ok & rst_n_in;

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + (ADDR_W+1)'(1);
    else if (rd_ok && !wr_ok)
      count_next = count - (ADDR_W+1)'(1);
  end

  // Storage has no reset, like the SRL primitive. The empty gating on the
  // read tap keeps stale contents from ever being visible.
  always_ff @(posedge clk_in) begin
    if (shift_en) begin
      srl[0] <= wr_data_in;
      for (int i = 1; i < DEPTH; i++)
        srl[i] <= srl[i-1];
    end
  end

  // Flags are registered from next-count so they always agree with count.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count     <= '0;
      empty_out <= 1'b1;
      full_out  <= 1'b0;
    end else begin
      count     <= count_next;
      empty_out <= (count_next == '0);
      full_out  <= (count_next == DEPTH_C);
    end
  end

`ifdef SRL_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ovf_out <= 1'b0;
      udf_out <= 1'b0;
    end else begin
      if (wr_en_in && !wr_ok)
        ovf_out <= 1'b1;
      if (rd_en_in && empty_out)
        udf_out <= 1'b1;
    end
  end
`endif

  // When count == DEPTH the low bits wrap to zero, and subtracting one gives
  // DEPTH-1, which is the correct tap for a full FIFO.
  assign tap_addr    = count[ADDR_W-1:0] - ADDR_W'(1);
  assign rd_data_out = empty_out ? '0 : srl[tap_addr];
  assign count_out   = count;

endmodule

// File: tb/tb_srl_fifo.sv
// tb_srl_fifo
//   Directed bench for srl_fifo. A vector table covers reset, ordering and
//   empty-side corners. Hand-written sequences then cover fill to full,
//   push while full, push plus pop while full with a full drain, and reset
//   in the middle of a stream.

module tb_srl_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk_in;
  logic              rst_n_in;
  logic              wr_en_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              rd_en_in;
  logic [DATA_W-1:0] rd_data_out;
  logic              full_out;
  logic              empty_out;
  logic [ADDR_W:0]   count_out;
`ifdef SRL_FIFO_ERR_FLAG_EN
  logic              ovf_out;
  logic              udf_out;
`endif

  int vec_count;
  int miss_count;

  srl_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .wr_en_in    (wr_en_in),
    .wr_data_in  (wr_data_in),
    .rd_en_in    (rd_en_in),
    .rd_data_out (rd_data_out),
    .full_out    (full_out),
    .empty_out   (empty_out),
`ifdef SRL_FIFO_ERR_FLAG_EN
    .ovf_out     (ovf_out),
    .udf_out     (udf_out),
`endif
    .count_out   (count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    int         exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst_n, input logic wr_en,
                               input logic [7:0] wr_data, input logic rd_en);
    rst_n_in   = rst_n;
    wr_en_in   = wr_en;
    wr_data_in = wr_data;
    rd_en_in   = rd_en;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input int exp_count,
                             input logic exp_empty, input logic exp_full,
                             input logic [7:0] exp_data);
    vec_count++;
    if (int'(count_out) != exp_count || empty_out !== exp_empty ||
        full_out !== exp_full || rd_data_out !== exp_data) begin
      miss_count++;
      $display("[TB] FAIL %s: got count=%0d empty=%b full=%b data=%h, want count=%0d empty=%b full=%b data=%h",
               name, count_out, empty_out, full_out, rd_data_out,
               exp_count, exp_empty, exp_full, exp_data);
    end
  endtask

`ifdef SRL_FIFO_ERR_FLAG_EN
  task automatic checkFlags(input string name, input logic exp_ovf,
                            input logic exp_udf);
    vec_count++;
    if (ovf_out !== exp_ovf || udf_out !== exp_udf) begin
      miss_count++;
      $display("[TB] FAIL %s: got ovf=%b udf=%b, want ovf=%b udf=%b",
               name, ovf_out, udf_out, exp_ovf, exp_udf);
    end
  endtask
`endif

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst_n_in   = 1'b0;
    wr_en_in   = 1'b1;
    wr_data_in = 8'hFF;
    rd_en_in   = 1'b0;

    //          name              rst   wr    data   rd    cnt e     f     data
    vecs[0]  = '{"reset_1",       1'b0, 1'b1, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{"reset_2",       1'b0, 1'b1, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{"push_11",       1'b1, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 8'h11};
    vecs[3]  = '{"push_22",       1'b1, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h11};
    vecs[4]  = '{"push_33",       1'b1, 1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 8'h11};
    vecs[5]  = '{"pop_1",         1'b1, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'h22};
    vecs[6]  = '{"pop_2",         1'b1, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h33};
    vecs[7]  = '{"pop_3",         1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{"pop_empty",     1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{"pushpop_empty", 1'b1, 1'b1, 8'h5A, 1'b1, 1, 1'b0, 1'b0, 8'h5A};
    vecs[10] = '{"pushpop_mid",   1'b1, 1'b1, 8'h66, 1'b1, 1, 1'b0, 1'b0, 8'h66};
    vecs[11] = '{"pop_last",      1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].rst_n, vecs[v].wr_en, vecs[v].wr_data, vecs[v].rd_en);
      checkOutput(vecs[v].name, vecs[v].exp_count, vecs[v].exp_empty,
                  vecs[v].exp_full, vecs[v].exp_data);
    end

`ifdef SRL_FIFO_ERR_FLAG_EN
    checkFlags("flags_after_table", 1'b0, 1'b1);
`endif

    // Fill to full with 0..31; the head stays at the first word pushed.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0);
    checkOutput("fill_full", 32, 1'b0, 1'b1, 8'h00);

    // A push into a full FIFO without a pop must be dropped.
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0);
    checkOutput("push_when_full", 32, 1'b0, 1'b1, 8'h00);
`ifdef SRL_FIFO_ERR_FLAG_EN
    checkFlags("ovf_set", 1'b1, 1'b1);
`endif

    // Push plus pop while full: word 0 leaves, 0xBB enters at the tail.
    applyStimulus(1'b1, 1'b1, 8'hBB, 1'b1);
    checkOutput("pushpop_full", 32, 1'b0, 1'b1, 8'h01);

    // Drain: 2..31 appear in order, then 0xBB is the last word out.
    for (int j = 1; j <= DEPTH; j++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      if (j < DEPTH - 1)
        checkOutput("drain", DEPTH - j, 1'b0, 1'b0, 8'(j + 1));
      else if (j == DEPTH - 1)
        checkOutput("drain_last_bb", 1, 1'b0, 1'b0, 8'hBB);
      else
        checkOutput("drain_empty", 0, 1'b1, 1'b0, 8'h00);
    end

    // Reset mid-stream with a push pending; nothing stale may resurface.
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
    checkOutput("midstream_count5", 5, 1'b0, 1'b0, 8'h41);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
    checkOutput("midstream_reset", 0, 1'b1, 1'b0, 8'h00);
`ifdef SRL_FIFO_ERR_FLAG_EN
    checkFlags("flags_cleared", 1'b0, 1'b0);
`endif
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    checkOutput("push_after_reset", 1, 1'b0, 1'b0, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("pop_after_reset", 0, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
